// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/sequencing controller:
//   - pctrl_state_e : controller FSM state encoding (S_RUN, S_MUL)
//   - DEF_MUL_CYCLES: default EX occupancy of an M-extension op
//   - ZERO_REG      : architectural x0, never a real hazard source
//   - load_use_hit(): load-use hazard predicate
package pipe_ctrl_pkg;

    typedef enum logic {
        S_RUN = 1'b0,
        S_MUL = 1'b1
    } pctrl_state_e;

    localparam int DEF_MUL_CYCLES = 4;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // A load in EX whose destination is read by decode forces a one-cycle
    // bubble. Writes to x0 are discarded by the register file, so they never
    // create a dependency.
    function automatic logic load_use_hit(
        input logic       is_load,
        input logic       reg_we,
        input logic [4:0] waddr,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return is_load && reg_we && (waddr != ZERO_REG) &&
               ((waddr == rs1) || (waddr == rs2));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
// Bundle between the core datapath (master) and the hazard controller (slave).
//   master drives: decode register addresses, EX instruction info, the
//                  M-op start pulse and the EX branch/jump result.
//   slave drives : stall/flush/redirect controls, M-op busy/done and the
//                  controller state for observation.
// Signalling: there is no valid/ready pair here. ex_muldiv_start_i is a
// single-cycle request that is always accepted when the controller is in
// S_RUN and no jump wins priority; acceptance is visible the same cycle as
// all three stalls going high, and completion as a one-cycle muldiv_done_o.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [4:0]   id_rs1_addr_i;
    logic [4:0]   id_rs2_addr_i;
    logic         ex_reg_we_i;
    logic [4:0]   ex_reg_waddr_i;
    logic         ex_is_load_i;
    logic         ex_muldiv_start_i;
    logic         ex_jump_en_i;
    logic [31:0]  ex_jump_addr_i;

    logic         stall_pc_o;
    logic         stall_if_id_o;
    logic         stall_id_ex_o;
    logic         flush_if_id_o;
    logic         flush_id_ex_o;
    logic         jump_en_o;
    logic [31:0]  jump_addr_o;
    logic         muldiv_busy_o;
    logic         muldiv_done_o;
    pctrl_state_e state_dbg;

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, ex_reg_we_i, ex_reg_waddr_i,
               ex_is_load_i, ex_muldiv_start_i, ex_jump_en_i, ex_jump_addr_i,
        input  stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o,
               flush_id_ex_o, jump_en_o, jump_addr_o, muldiv_busy_o,
               muldiv_done_o, state_dbg
    );

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, ex_reg_we_i, ex_reg_waddr_i,
               ex_is_load_i, ex_muldiv_start_i, ex_jump_en_i, ex_jump_addr_i,
        output stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o,
               flush_id_ex_o, jump_en_o, jump_addr_o, muldiv_busy_o,
               muldiv_done_o, state_dbg
    );

endinterface

// File: rtl/pipe_ctrl_mul_timer.sv
// pipe_ctrl_mul_timer
// Holds the S_RUN/S_MUL state and the down-counter that keeps an M-op in EX.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : accepted M-op start (already priority-qualified by the top)
//   busy       : in S_MUL
//   stall      : in S_MUL with cycles still remaining
//   done       : last S_MUL cycle (cnt == 0)
//   state      : current FSM state, for observation
module pipe_ctrl_mul_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int CNT_W      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output pctrl_state_e state
);

    // The start cycle is spent in S_RUN, so S_MUL lasts MUL_CYCLES-1 cycles:
    // counting from MUL_CYCLES-2 down to 0 inclusive.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (start) begin
                        state <= S_MUL;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_MUL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy  = (state == S_MUL);
    assign stall = busy && (cnt != '0);
    assign done  = busy && (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Hazard and sequencing controller for the 5-stage RV32IM pipeline.
// Detects load-use hazards, applies EX jump redirects with a two-stage flush,
// and holds multi-cycle M-ops in EX via pipe_ctrl_mul_timer.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset; forces every output to 0
//   bus   : pipe_ctrl_if.slave (decode/EX inputs, stall/flush/redirect outputs)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
);

    if (MUL_CYCLES < 2 || MUL_CYCLES > 16 || (MUL_CYCLES - 2) >= (2 ** CNT_W)) begin : g_param_check
        $error("pipe_ctrl: MUL_CYCLES must be 2..16 and MUL_CYCLES-2 must fit in CNT_W bits");
    end

    logic         mul_start;
    logic         mul_busy;
    logic         mul_stall;
    logic         mul_done;
    pctrl_state_e state;
    logic         load_use;

    pipe_ctrl_mul_timer #(
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) u_mul_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .busy  (mul_busy),
        .stall (mul_stall),
        .done  (mul_done),
        .state (state)
    );

    assign load_use = load_use_hit(bus.ex_is_load_i, bus.ex_reg_we_i, bus.ex_reg_waddr_i,
                                   bus.id_rs1_addr_i, bus.id_rs2_addr_i);

    // Responses are combinational so the pipeline reacts in the same cycle.
    // rst_n gates every output because jump/load-use paths come straight
    // from inputs and must read 0 while reset is held.
    always_comb begin
        bus.stall_pc_o    = 1'b0;
        bus.stall_if_id_o = 1'b0;
        bus.stall_id_ex_o = 1'b0;
        bus.flush_if_id_o = 1'b0;
        bus.flush_id_ex_o = 1'b0;
        bus.jump_en_o     = 1'b0;
        bus.jump_addr_o   = 32'h0;
        bus.muldiv_busy_o = 1'b0;
        bus.muldiv_done_o = 1'b0;
        mul_start         = 1'b0;
        if (rst_n) begin
            if (mul_busy) begin
                // EX owns the M-op; jumps and load-use cannot occur behind it
                // because the younger stages are frozen.
                bus.muldiv_busy_o = 1'b1;
                bus.muldiv_done_o = mul_done;
                bus.stall_pc_o    = mul_stall;
                bus.stall_if_id_o = mul_stall;
                bus.stall_id_ex_o = mul_stall;
            end else if (bus.ex_jump_en_i) begin
                bus.jump_en_o     = 1'b1;
                bus.jump_addr_o   = bus.ex_jump_addr_i;
                bus.flush_if_id_o = 1'b1;
                bus.flush_id_ex_o = 1'b1;
            end else if (bus.ex_muldiv_start_i) begin
                mul_start         = 1'b1;
                bus.stall_pc_o    = 1'b1;
                bus.stall_if_id_o = 1'b1;
                bus.stall_id_ex_o = 1'b1;
            end else if (load_use) begin
                // Hold fetch/decode, insert a bubble behind the load.
                bus.stall_pc_o    = 1'b1;
                bus.stall_if_id_o = 1'b1;
                bus.flush_id_ex_o = 1'b1;
            end
        end
    end

    assign bus.state_dbg = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Directed bench for pipe_ctrl. dut_a runs MUL_CYCLES=4, dut_b MUL_CYCLES=2.
// Inputs are driven on the falling edge; outputs are checked 1 ns later.
// Control vector order: {stall_pc, stall_if_id, stall_id_ex, flush_if_id,
//                        flush_id_ex, jump_en, busy, done}
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pipe_ctrl_if bus_a ();
    pipe_ctrl_if bus_b ();

    pipe_ctrl #(.MUL_CYCLES(4), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    pipe_ctrl #(.MUL_CYCLES(2), .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    logic [7:0] ctl_a;
    logic [7:0] ctl_b;
    assign ctl_a = {bus_a.stall_pc_o, bus_a.stall_if_id_o, bus_a.stall_id_ex_o, bus_a.flush_if_id_o,
                    bus_a.flush_id_ex_o, bus_a.jump_en_o, bus_a.muldiv_busy_o, bus_a.muldiv_done_o};
    assign ctl_b = {bus_b.stall_pc_o, bus_b.stall_if_id_o, bus_b.stall_id_ex_o, bus_b.flush_if_id_o,
                    bus_b.flush_id_ex_o, bus_b.jump_en_o, bus_b.muldiv_busy_o, bus_b.muldiv_done_o};

    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic idle_a();
        bus_a.id_rs1_addr_i     = 5'd0;
        bus_a.id_rs2_addr_i     = 5'd0;
        bus_a.ex_reg_we_i       = 1'b0;
        bus_a.ex_reg_waddr_i    = 5'd0;
        bus_a.ex_is_load_i      = 1'b0;
        bus_a.ex_muldiv_start_i = 1'b0;
        bus_a.ex_jump_en_i      = 1'b0;
        bus_a.ex_jump_addr_i    = 32'h0;
    endtask

    task automatic idle_b();
        bus_b.id_rs1_addr_i     = 5'd0;
        bus_b.id_rs2_addr_i     = 5'd0;
        bus_b.ex_reg_we_i       = 1'b0;
        bus_b.ex_reg_waddr_i    = 5'd0;
        bus_b.ex_is_load_i      = 1'b0;
        bus_b.ex_muldiv_start_i = 1'b0;
        bus_b.ex_jump_en_i      = 1'b0;
        bus_b.ex_jump_addr_i    = 32'h0;
    endtask

    task automatic drive_load(input logic is_load, input logic we, input logic [4:0] waddr,
                              input logic [4:0] rs1, input logic [4:0] rs2);
        bus_a.ex_is_load_i   = is_load;
        bus_a.ex_reg_we_i    = we;
        bus_a.ex_reg_waddr_i = waddr;
        bus_a.id_rs1_addr_i  = rs1;
        bus_a.id_rs2_addr_i  = rs2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        bus_a.ex_jump_en_i   = 1'b1;
        bus_a.ex_jump_addr_i = 32'h0000_0100;
        drive_load(1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
        #1;
        total++;
        if (ctl_a !== 8'b0) begin
            bad++; $display("FAIL reset_ctl: actual=%b required=%b", ctl_a, 8'b0);
        end
        total++;
        if (bus_a.jump_addr_o !== 32'h0) begin
            bad++; $display("FAIL reset_jump_addr: actual=%h required=%h", bus_a.jump_addr_o, 32'h0);
        end
        total++;
        if (bus_a.state_dbg !== S_RUN) begin
            bad++; $display("FAIL reset_state: actual=%0d required=%0d", bus_a.state_dbg, S_RUN);
        end
        idle_a();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (ctl_a !== 8'b0 || ctl_b !== 8'b0) begin
            bad++; $display("FAIL post_reset_idle: actual=%b/%b required=%b", ctl_a, ctl_b, 8'b0);
        end
    endtask

    task automatic test_load_use();
        // lw x5 in EX, decode reads rs2=x5 -> bubble
        @(negedge clk);
        drive_load(1'b1, 1'b1, 5'd5, 5'd3, 5'd5);
        #1;
        total++;
        if (ctl_a !== 8'b11001000) begin
            bad++; $display("FAIL load_use_rs2: actual=%b required=%b", ctl_a, 8'b11001000);
        end
        // load has left EX
        @(negedge clk);
        drive_load(1'b0, 1'b1, 5'd7, 5'd3, 5'd5);
        #1;
        total++;
        if (ctl_a !== 8'b0) begin
            bad++; $display("FAIL load_use_clear: actual=%b required=%b", ctl_a, 8'b0);
        end
        // match on rs1
        @(negedge clk);
        drive_load(1'b1, 1'b1, 5'd12, 5'd12, 5'd1);
        #1;
        total++;
        if (ctl_a !== 8'b11001000) begin
            bad++; $display("FAIL load_use_rs1: actual=%b required=%b", ctl_a, 8'b11001000);
        end
        // destination x0 never hazards
        @(negedge clk);
        drive_load(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        total++;
        if (ctl_a !== 8'b0) begin
            bad++; $display("FAIL load_use_x0: actual=%b required=%b", ctl_a, 8'b0);
        end
        // load without register write
        @(negedge clk);
        drive_load(1'b1, 1'b0, 5'd5, 5'd5, 5'd5);
        #1;
        total++;
        if (ctl_a !== 8'b0) begin
            bad++; $display("FAIL load_use_no_we: actual=%b required=%b", ctl_a, 8'b0);
        end
        // ALU op with matching destination is forwarded, no stall
        @(negedge clk);
        drive_load(1'b0, 1'b1, 5'd5, 5'd5, 5'd5);
        #1;
        total++;
        if (ctl_a !== 8'b0) begin
            bad++; $display("FAIL load_use_non_load: actual=%b required=%b", ctl_a, 8'b0);
        end
        idle_a();
    endtask

    task automatic test_jump();
        @(negedge clk);
        bus_a.ex_jump_en_i   = 1'b1;
        bus_a.ex_jump_addr_i = 32'h0000_0100;
        drive_load(1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
        #1;
        total++;
        if (ctl_a !== 8'b00011100) begin
            bad++; $display("FAIL jump_ctl: actual=%b required=%b", ctl_a, 8'b00011100);
        end
        total++;
        if (bus_a.jump_addr_o !== 32'h0000_0100) begin
            bad++; $display("FAIL jump_addr: actual=%h required=%h", bus_a.jump_addr_o, 32'h0000_0100);
        end
        @(negedge clk);
        idle_a();
        #1;
        total++;
        if (ctl_a !== 8'b0 || bus_a.jump_addr_o !== 32'h0) begin
            bad++; $display("FAIL jump_release: actual=%b/%h required=%b/%h",
                            ctl_a, bus_a.jump_addr_o, 8'b0, 32'h0);
        end
    endtask

    task automatic test_mul();
        logic [4:0] start_seq;
        logic [4:0] jump_seq;
        logic [7:0] exp_v;
        start_seq = 5'b00001;
        jump_seq  = 5'b00100;  // jump + load-use during S_MUL must be ignored
        exp_q.push_back(8'b11100000);
        exp_q.push_back(8'b11100010);
        exp_q.push_back(8'b11100010);
        exp_q.push_back(8'b00000011);
        exp_q.push_back(8'b00000000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_a();
            bus_a.ex_muldiv_start_i = start_seq[i];
            if (jump_seq[i]) begin
                bus_a.ex_jump_en_i   = 1'b1;
                bus_a.ex_jump_addr_i = 32'hDEAD_BEE0;
                drive_load(1'b1, 1'b1, 5'd9, 5'd9, 5'd9);
            end
            #1;
            exp_v = exp_q.pop_front();
            total++;
            if (ctl_a !== exp_v || bus_a.jump_addr_o !== 32'h0) begin
                bad++; $display("FAIL mul4_cycle%0d: actual=%b/%h required=%b/%h",
                                i, ctl_a, bus_a.jump_addr_o, exp_v, 32'h0);
            end
        end
        total++;
        if (bus_a.state_dbg !== S_RUN) begin
            bad++; $display("FAIL mul4_end_state: actual=%0d required=%0d", bus_a.state_dbg, S_RUN);
        end
        idle_a();
    endtask

    task automatic test_jump_vs_start();
        @(negedge clk);
        bus_a.ex_jump_en_i      = 1'b1;
        bus_a.ex_jump_addr_i    = 32'h0000_0200;
        bus_a.ex_muldiv_start_i = 1'b1;
        #1;
        total++;
        if (ctl_a !== 8'b00011100 || bus_a.jump_addr_o !== 32'h0000_0200) begin
            bad++; $display("FAIL jump_vs_start: actual=%b/%h required=%b/%h",
                            ctl_a, bus_a.jump_addr_o, 8'b00011100, 32'h0000_0200);
        end
        @(negedge clk);
        idle_a();
        #1;
        total++;
        if (ctl_a !== 8'b0 || bus_a.state_dbg !== S_RUN) begin
            bad++; $display("FAIL jump_vs_start_after: actual=%b/%0d required=%b/%0d",
                            ctl_a, bus_a.state_dbg, 8'b0, S_RUN);
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen_done;
        @(negedge clk);
        bus_a.ex_muldiv_start_i = 1'b1;
        @(negedge clk);
        idle_a();
        #1;
        total++;
        if (ctl_a !== 8'b11100010) begin
            bad++; $display("FAIL mid_mul_busy: actual=%b required=%b", ctl_a, 8'b11100010);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (ctl_a !== 8'b0 || bus_a.state_dbg !== S_RUN) begin
            bad++; $display("FAIL mid_mul_reset: actual=%b/%0d required=%b/%0d",
                            ctl_a, bus_a.state_dbg, 8'b0, S_RUN);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (ctl_a !== 8'b0) seen_done++;
        end
        total++;
        if (seen_done != 0) begin
            bad++; $display("FAIL mid_mul_no_done: actual=%0d active_cycles required=0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] start_seq;
        logic [7:0] exp_v;
        start_seq = 4'b0101;
        exp_q.push_back(8'b11100000);
        exp_q.push_back(8'b00000011);
        exp_q.push_back(8'b11100000);
        exp_q.push_back(8'b00000011);
        exp_q.push_back(8'b00000000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_b();
            if (i < 4) bus_b.ex_muldiv_start_i = start_seq[i];
            #1;
            exp_v = exp_q.pop_front();
            total++;
            if (ctl_b !== exp_v) begin
                bad++; $display("FAIL mul2_b2b_cycle%0d: actual=%b required=%b", i, ctl_b, exp_v);
            end
        end
        idle_b();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_a();
        idle_b();
        test_reset();
        test_load_use();
        test_jump();
        test_mul();
        test_jump_vs_start();
        test_reset_mid_mul();
        test_back_to_back();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32IM core. It watches the register addresses decode is reading, the instruction in EX, and EX's branch/jump result, and drives the stall, flush and redirect signals for PC, IF/ID and ID/EX. It also times multi-cycle M-extension operations so EX holds them for a fixed latency.

## Interface
Parameters:
- MUL_CYCLES, 4, EX occupancy of one M-type op in cycles; legal range 2..16.
- CNT_W, 4, counter width; must satisfy 2^CNT_W >= MUL_CYCLES-1.

Ports:
- Reset is asynchronous and active-low.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1_addr_i  in  5  rs1 address presented by decode to the register file.
- id_rs2_addr_i  in  5  rs2 address presented by decode to the register file.
- ex_reg_we_i  in  1  instruction in EX writes a register.
- ex_reg_waddr_i  in  5  destination register of the instruction in EX.
- ex_is_load_i  in  1  instruction in EX is LB/LH/LW/LBU/LHU.
- ex_muldiv_start_i  in  1  valid M-type op in EX, first cycle only.
- ex_jump_en_i  in  1  EX resolved a taken branch, JAL or JALR.
- ex_jump_addr_i  in  32  target address from EX.
- stall_pc_o  out  1  hold PC.
- stall_if_id_o  out  1  hold the IF/ID register.
- stall_id_ex_o  out  1  hold the ID/EX register (EX keeps its op).
- flush_if_id_o  out  1  load NOP into IF/ID.
- flush_id_ex_o  out  1  load NOP into ID/EX (bubble).
- jump_en_o  out  1  redirect PC.
- jump_addr_o  out  32  redirect target.
- muldiv_busy_o  out  1  M-op sequencing in progress.
- muldiv_done_o  out  1  last EX cycle of the M-op; EX result valid.

## Operation
- States: S_RUN (reset), S_MUL. Down-counter cnt[CNT_W-1:0], reset 0.
- While rst_n is low, all outputs are 0, state is S_RUN and cnt is 0. This applies mid-S_MUL too: abort with no done pulse.
- In S_RUN, priority is highest first:
  1. ex_jump_en_i: jump_en_o=1, jump_addr_o=ex_jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1. Any simultaneous start or load-use is ignored.
  2. ex_muldiv_start_i: stall_pc_o, stall_if_id_o and stall_id_ex_o are 1. On the next edge, go to S_MUL with cnt=MUL_CYCLES-2.
  3. Load-use: asserted when ex_is_load_i & ex_reg_we_i & ex_reg_waddr_i!=0 & (ex_reg_waddr_i==id_rs1_addr_i | ex_reg_waddr_i==id_rs2_addr_i). Response: stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1 for exactly this cycle. It is combinational and clears once the load leaves EX.
  4. Otherwise all control outputs are 0.
- In S_MUL:
  - muldiv_busy_o=1. ex_jump_en_i and load-use are ignored, and jump_en_o is forced to 0.
  - cnt!=0: stall_pc_o, stall_if_id_o and stall_id_ex_o are 1; cnt decrements.
  - cnt==0: muldiv_done_o=1 and all stalls are 0, so the pipeline advances at this edge. Next state is S_RUN.
- jump_addr_o is 0 whenever jump_en_o is 0.
- Arithmetic: cnt is unsigned and never decrements below 0. MUL_CYCLES-2 must fit in CNT_W bits (elaboration check).

## Timing
- Jump, load-use and start responses are combinational in the same cycle as their inputs. There is no added latency.
- An M-op occupies EX for exactly MUL_CYCLES cycles: the start cycle plus MUL_CYCLES-1 cycles in S_MUL.
- muldiv_done_o is a 1-cycle pulse in the last of those cycles.
- The load-use bubble is exactly 1 cycle.
- A jump flush is exactly 1 cycle. It affects the two younger stages, and no wrong-path instruction reaches EX.
- Back-to-back M-ops: a new start in the cycle after done is accepted normally from S_RUN.

## Structure
- defines.v gets the following, alongside the existing opcode macros:
  - state encodings `PCTRL_S_RUN / `PCTRL_S_MUL;
  - default `MUL_CYCLES;
  - `ZeroReg reused for the x0 check.
- One sub-module is natural: pipe_ctrl_mul_timer, holding the S_MUL state and cnt, with start/done/busy ports. Hazard detection and the priority mux stay in pipe_ctrl.

## Test plan
- Load-use: EX has lw x5 with we=1; decode reads rs2=x5 -> stall_pc/stall_if_id/flush_id_ex=1 for 1 cycle, then 0. Repeat with waddr=x0 -> no stall.
- Jump: ex_jump_en_i=1, addr=0x0000_0100 -> same cycle jump_en_o=1, jump_addr_o=0x100, both flushes=1; next cycle all 0.
- M-op with MUL_CYCLES=4: start pulse at cycle t -> stalls 1 at t..t+2, done=1 and stalls 0 at t+3, busy=1 at t+1..t+3.
- Simultaneous jump and start in S_RUN -> jump response only; state stays S_RUN, busy stays 0.
- Reset asserted at t+1 of an M-op -> all outputs 0 immediately; after release, state is S_RUN and there is no done pulse.
- MUL_CYCLES=2 -> a single S_MUL cycle with done=1; back-to-back starts give done pulses 2 cycles apart.
